// File: rtl/nco_phase_accumulator.sv
// Numerically controlled oscillator: a sample-rate divider, a phase accumulator
// and a waveform shaper, with one new audio sample every CLK_DIV system clocks.
module nco_phase_accumulator #(
    parameter int unsigned CLK_DIV   = 1042,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nco_increment_value,
    input  logic        nco_mute,
    input  logic [1:0]  wave_select,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        phase_wrap
);

    localparam int unsigned CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SAMPLE_W = 16;

    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [1:0]          WAVE_SAW  = 2'b00;
    localparam logic [1:0]          WAVE_SQR  = 2'b01;
    localparam logic [1:0]          WAVE_TRI  = 2'b10;
    localparam logic [SAMPLE_W-1:0] SIGN_FLIP = 16'h8000;

    logic [CNT_W-1:0]     div_cnt;
    logic                 tick_c;
    logic [ACC_WIDTH-1:0] phase;
    logic                 carry;
    logic [ACC_WIDTH:0]   sum_c;
    logic                 pipe_valid;
    logic                 pipe_silent;
    logic [1:0]           pipe_wave;
    logic [SAMPLE_W-1:0]  p_c;
    logic [SAMPLE_W-1:0]  tri_c;
    logic [SAMPLE_W-1:0]  wave_c;

    assign tick_c = (div_cnt == CNT_MAX);
    assign sum_c  = {1'b0, phase} + (ACC_WIDTH + 1)'(nco_increment_value);

    // Sample-rate divider: counts 0..CLK_DIV-1, tick on the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Phase stage: inputs are only looked at on tick; mute parks phase at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase       <= '0;
            carry       <= 1'b0;
            pipe_valid  <= 1'b0;
            pipe_silent <= 1'b0;
            pipe_wave   <= WAVE_SAW;
        end else begin
            pipe_valid <= tick_c;
            if (tick_c) begin
                pipe_wave   <= wave_select;
                pipe_silent <= nco_mute | (wave_select == 2'b11);
                if (nco_mute) begin
                    phase <= '0;
                    carry <= 1'b0;
                end else begin
                    phase <= sum_c[ACC_WIDTH-1:0];
                    carry <= sum_c[ACC_WIDTH];
                end
            end
        end
    end

    // Waveform shaper on the top 16 bits of the freshly updated phase.
    always_comb begin
        p_c    = phase[ACC_WIDTH-1 -: SAMPLE_W];
        tri_c  = p_c[15] ? ~{p_c[14:0], 1'b0} : {p_c[14:0], 1'b0};
        wave_c = '0;
        if (!pipe_silent) begin
            case (pipe_wave)
                WAVE_SAW: wave_c = p_c ^ SIGN_FLIP;
                WAVE_SQR: wave_c = p_c[15] ? 16'h8001 : 16'h7FFF;
                WAVE_TRI: wave_c = tri_c ^ SIGN_FLIP;
                default:  wave_c = '0;
            endcase
        end
    end

    // Output stage: one-cycle strobes, sample held between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            phase_wrap   <= 1'b0;
        end else begin
            sample_valid <= pipe_valid;
            phase_wrap   <= pipe_valid & carry;
            if (pipe_valid) begin
                sample_out <= wave_c;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Directed bench for nco_phase_accumulator at CLK_DIV=4, ACC_WIDTH=20.
module tb_nco_phase_accumulator;

    logic        clk;
    logic        rst;
    logic [15:0] nco_increment_value;
    logic        nco_mute;
    logic [1:0]  wave_select;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        phase_wrap;

    int          n_cmp;
    int          n_err;
    int          cyc;
    logic [19:0] m_phase;
    logic        m_carry;
    logic [15:0] last_sample;
    logic        last_wrap;

    nco_phase_accumulator #(
        .CLK_DIV  (4),
        .ACC_WIDTH(20)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .nco_increment_value(nco_increment_value),
        .nco_mute           (nco_mute),
        .wave_select        (wave_select),
        .sample_out         (sample_out),
        .sample_valid       (sample_valid),
        .phase_wrap         (phase_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] w, input logic m, input logic [19:0] ph);
        logic [15:0] p;
        logic [15:0] t;
        p = ph[19:4];
        t = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
        if (m) return 16'h0000;
        case (w)
            2'b00:   return p ^ 16'h8000;
            2'b01:   return p[15] ? 16'h8001 : 16'h7FFF;
            2'b10:   return t ^ 16'h8000;
            default: return 16'h0000;
        endcase
    endfunction

    // Wait (bounded) for the next strobe, advance the model, compare the sample.
    task automatic get_sample(output int c);
        logic [20:0] s;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!sample_valid && c < 40);
        check1("strobe_seen", sample_valid, 1'b1);
        if (nco_mute) begin
            m_phase = '0;
            m_carry = 1'b0;
        end else begin
            s       = {1'b0, m_phase} + 21'(nco_increment_value);
            m_phase = s[19:0];
            m_carry = s[20];
        end
        check16("sample_model", sample_out, model(wave_select, nco_mute, m_phase));
        check1("wrap_model", phase_wrap, m_carry);
        last_sample = sample_out;
        last_wrap   = phase_wrap;
    endtask

    task automatic run(input int n, input logic [15:0] inc, input logic [1:0] w, input logic m);
        int c;
        nco_increment_value = inc;
        wave_select         = w;
        nco_mute            = m;
        for (int i = 0; i < n; i++) get_sample(c);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_phase = '0;
        m_carry = 1'b0;
        rst = 1'b0;
        nco_increment_value = 16'h1000;
        nco_mute = 1'b0;
        wave_select = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        check16("reset_sample", sample_out, 16'h0000);
        check1("reset_valid", sample_valid, 1'b0);
        check1("reset_wrap", phase_wrap, 1'b0);

        // Release: first strobe five cycles later, saw from phase zero
        rst = 1'b1;
        get_sample(cyc);
        check_int("first_strobe_latency", cyc, 5);
        check16("saw_first", last_sample, 16'h8100);
        @(negedge clk);
        check1("valid_one_cycle", sample_valid, 1'b0);
        check1("wrap_one_cycle", phase_wrap, 1'b0);
        check16("sample_held", sample_out, 16'h8100);

        // Saw sweep up to the 256th sample, which wraps
        run(1, 16'h1000, 2'b00, 1'b0);
        check16("saw_second", last_sample, 16'h8200);
        run(254, 16'h1000, 2'b00, 1'b0);
        check16("saw_256", last_sample, 16'h8000);
        check1("saw_256_wrap", last_wrap, 1'b1);

        // Square
        run(15, 16'h8000, 2'b01, 1'b0);
        check16("square_15", last_sample, 16'h7FFF);
        run(1, 16'h8000, 2'b01, 1'b0);
        check16("square_16", last_sample, 16'h8001);
        check1("square_16_wrap", last_wrap, 1'b0);
        run(16, 16'h8000, 2'b01, 1'b0);
        check16("square_32", last_sample, 16'h7FFF);
        check1("square_32_wrap", last_wrap, 1'b1);

        // Triangle at p = 4000, C000, 0000
        run(16, 16'h4000, 2'b10, 1'b0);
        check16("tri_4000", last_sample, 16'h0000);
        run(32, 16'h4000, 2'b10, 1'b0);
        check16("tri_C000", last_sample, 16'hFFFF);
        run(16, 16'h4000, 2'b10, 1'b0);
        check16("tri_0000", last_sample, 16'h8000);
        check1("tri_wrap", last_wrap, 1'b1);

        // Mute mid-run, then unmute resumes from zero
        run(2, 16'h1000, 2'b00, 1'b0);
        check16("pre_mute", last_sample, 16'h8200);
        run(1, 16'h1000, 2'b00, 1'b1);
        check16("muted", last_sample, 16'h0000);
        check1("muted_wrap", last_wrap, 1'b0);
        run(1, 16'h1000, 2'b00, 1'b0);
        check16("unmuted", last_sample, 16'h8100);

        // Inputs toggled between ticks and restored have no effect
        nco_increment_value = 16'hFFFF;
        wave_select = 2'b11;
        nco_mute = 1'b1;
        @(negedge clk);
        check16("offtick_held", sample_out, 16'h8100);
        check1("offtick_no_strobe", sample_valid, 1'b0);
        nco_increment_value = 16'h1000;
        wave_select = 2'b00;
        nco_mute = 1'b0;
        get_sample(cyc);
        check_int("offtick_spacing", cyc, 3);
        check16("offtick_sample", last_sample, 16'h8200);

        // Silent waveform still strobes; phase keeps advancing
        run(1, 16'h1000, 2'b11, 1'b0);
        check16("silent", last_sample, 16'h0000);
        run(1, 16'h1000, 2'b00, 1'b0);
        check16("after_silent", last_sample, 16'h8400);

        // Increment zero gives DC
        run(2, 16'h0000, 2'b00, 1'b0);
        check16("dc_hold", last_sample, 16'h8400);

        // Reset with a sample in flight: outputs clear at once, sample discarded
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check16("midreset_sample", sample_out, 16'h0000);
        check1("midreset_valid", sample_valid, 1'b0);
        check1("midreset_wrap", phase_wrap, 1'b0);
        repeat (2) @(negedge clk);
        check1("inreset_no_strobe", sample_valid, 1'b0);
        m_phase = '0;
        nco_increment_value = 16'h1000;
        wave_select = 2'b00;
        nco_mute = 1'b0;
        rst = 1'b1;
        get_sample(cyc);
        check_int("post_reset_latency", cyc, 5);
        check16("post_reset_sample", last_sample, 16'h8100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
